// File: rtl/spike_count_classifier.sv
// -----------------------------------------------------------------------------
// spike_count_classifier
//   Counts output spikes per class over a fixed window of ACCUM cycles (with an
//   optional early stop once one class leads the runner-up by EARLY_MARGIN),
//   then reports the winning class index and a tie flag through a
//   valid/ready handshake.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   reset      : synchronous, active-high reset
//   start      : request a new classification window (honoured in IDLE only)
//   spk_in     : one spike bit per class, sampled every ACCUM cycle
//   out_ready  : consumer accepts the result (honoured in HOLD only)
//   busy       : high in ACCUM, DECIDE and HOLD
//   out_valid  : result valid
//   label      : winning class index (lowest index wins ties)
//   tie        : winning count shared by at least two classes
//   counts     : per-class counters, class i at [CNT_W*i +: CNT_W]
// -----------------------------------------------------------------------------
module spike_count_classifier #(
  parameter  int N_CLASSES    = 2,
  parameter  int WINDOW       = 15,
  parameter  int CNT_W        = 8,
  parameter  int EARLY_MARGIN = 0,
  localparam int LBL_W        = (N_CLASSES > 2) ? $clog2(N_CLASSES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [N_CLASSES-1:0]       spk_in,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       out_valid,
  output logic [LBL_W-1:0]           label,
  output logic                       tie,
  output logic [N_CLASSES*CNT_W-1:0] counts
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DECIDE,
    S_HOLD
  } state_e;

  typedef logic [CNT_W-1:0] cnt_arr_t [N_CLASSES];

  // Leader, runner-up and leader index of a set of counters.
  typedef struct packed {
    logic [CNT_W-1:0] max_v;
    logic [CNT_W-1:0] sec_v;
    logic [LBL_W-1:0] idx;
  } rank_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [15:0]      WINDOW_M1 = 16'(WINDOW - 1);

  state_e           state_q;
  logic [15:0]      tick_q;
  cnt_arr_t         cnt_q;
  cnt_arr_t         cnt_d;
  logic [LBL_W-1:0] label_q;
  logic             tie_q;
  logic             valid_q;
  rank_t            rank_upd;
  rank_t            rank_cur;
  logic             early_hit;

  // Strict '>' keeps the lowest index on equal counts. The runner-up skips
  // only the leader's index, so a tie shows up as sec_v == max_v.
  function automatic rank_t rank_of(input cnt_arr_t c);
    rank_t r;
    r.max_v = c[0];
    r.idx   = '0;
    for (int i = 1; i < N_CLASSES; i++) begin
      if (c[i] > r.max_v) begin
        r.max_v = c[i];
        r.idx   = LBL_W'(i);
      end
    end
    r.sec_v = '0;
    for (int i = 0; i < N_CLASSES; i++) begin
      if (LBL_W'(i) != r.idx && c[i] > r.sec_v) r.sec_v = c[i];
    end
    return r;
  endfunction

  // Saturating per-class increment; only committed while in ACCUM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    for (int i = 0; i < N_CLASSES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (spk_in[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  // Early stop looks at the counts being written this cycle, so the window
  // closes on the same edge that first makes the lead large enough.
  assign rank_upd  = rank_of(cnt_d);
  assign rank_cur  = rank_of(cnt_q);
  assign early_hit = (EARLY_MARGIN > 0) &&
                     (int'(rank_upd.max_v - rank_upd.sec_v) >= EARLY_MARGIN);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      // NOTE: the counters are a handful of flops, not a RAM, so they are
      // reset along with the rest of the state.
      for (int i = 0; i < N_CLASSES; i++) cnt_q[i] <= '0;
      label_q <= '0;
      tie_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Counters keep the last result visible until a new window starts.
          if (start) begin
            for (int i = 0; i < N_CLASSES; i++) cnt_q[i] <= '0;
            tick_q  <= '0;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          cnt_q  <= cnt_d;
          tick_q <= tick_q + 16'd1;
          if (tick_q == WINDOW_M1 || early_hit) state_q <= S_DECIDE;
        end
        S_DECIDE: begin
          label_q <= rank_cur.idx;
          tie_q   <= (rank_cur.sec_v == rank_cur.max_v);
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          // out_valid rises one cycle into HOLD; the handshake only counts
          // once the consumer has actually seen it high.
          if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = valid_q;
  assign label     = label_q;
  assign tie       = tie_q;

  always_comb begin
    counts = '0;
    for (int i = 0; i < N_CLASSES; i++) counts[CNT_W*i +: CNT_W] = cnt_q[i];
  end

endmodule

// File: doc/spike_count_classifier.md
SPIKE_COUNT_CLASSIFIER -- requirements
Module: spike_count_classifier

Interface
REQ-001 SHALL have parameter N_CLASSES, default 2: number of output spike channels (2..16).
REQ-002 SHALL have parameter WINDOW, default 15: ACCUM cycles per classification (1..2^16-1).
REQ-003 SHALL have parameter CNT_W, default 8: per-channel spike counter width.
REQ-004 SHALL have parameter EARLY_MARGIN, default 0: lead over runner-up that ends the window early; 0 disables early stop.
REQ-005 SHALL have localparam LBL_W = max(1, clog2(N_CLASSES)).
REQ-006 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port start  in  1  request a new classification window.
REQ-009 SHALL have port spk_in  in  N_CLASSES  one spike bit per class, sampled each ACCUM cycle.
REQ-010 SHALL have port out_ready  in  1  consumer accepts result.
REQ-011 SHALL have port busy  out  1  high in ACCUM, DECIDE and HOLD.
REQ-012 SHALL have port out_valid  out  1  result valid.
REQ-013 SHALL have port label  out  LBL_W  winning class index.
REQ-014 SHALL have port tie  out  1  winning count shared by at least two classes.
REQ-015 SHALL have port counts  out  N_CLASSES*CNT_W  registered counters, class i at [CNT_W*i +: CNT_W].

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, DECIDE, HOLD.
REQ-017 IDLE with start=1 SHALL clear all counters and the window tick counter and move to ACCUM; start=0 stays in IDLE.
REQ-018 Each ACCUM cycle SHALL increment counter i when spk_in[i]=1, saturating at 2^CNT_W-1 (no wrap).
REQ-019 ACCUM SHALL last exactly WINDOW cycles, then move to DECIDE.
REQ-020 With EARLY_MARGIN>0, ACCUM SHALL move to DECIDE on the cycle after the registered counts show max minus second-max >= EARLY_MARGIN, checked after each update.
REQ-021 DECIDE (one cycle) SHALL register label = index of the maximum count, lowest index winning ties, and tie=1 if any other class equals the maximum; it then moves to HOLD.
REQ-022 HOLD SHALL assert out_valid and keep label, tie and counts stable until out_ready=1, then return to IDLE on the next edge.
REQ-023 Latency SHALL be: start sampled at edge k -> out_valid high after edge k+WINDOW+2 (no early stop).
REQ-024 start SHALL be ignored outside IDLE, including the cycle out_valid and out_ready handshake.
REQ-025 spk_in SHALL be ignored outside ACCUM.
REQ-026 The counts output SHALL reflect live counters during ACCUM and hold their final values through HOLD and IDLE until the next start.
REQ-027 out_ready SHALL be ignored outside HOLD.

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE, counters and tick to 0, out_valid=0, busy=0, label=0, tie=0, counts=0, in any state.
REQ-029 reset SHALL take priority over start, spk_in and out_ready in the same cycle.
REQ-030 After reset deasserts, the first start in IDLE SHALL be accepted normally.

Verification
REQ-031 Defaults; start, then spk_in=2'b10 for 15 cycles -> counts={15,0}, label=1, tie=0, out_valid 17 cycles after start.
REQ-032 Defaults; spk_in=2'b11 every cycle -> counts={15,15}, label=0, tie=1.
REQ-033 CNT_W=3; spk_in=2'b01 for 15 cycles -> count0=7 (saturated), count1=0, label=0.
REQ-034 EARLY_MARGIN=4; spk_in=2'b01 constantly -> DECIDE after 4 ACCUM cycles, count0=4, label=0, out_valid 6 cycles after start.
REQ-035 N_CLASSES=5; spikes total {3,9,9,1,0} -> label=1, tie=1; out_ready held low 10 cycles -> outputs stable, start pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-036 reset pulsed in ACCUM cycle 7 -> all outputs 0 on the next edge; a following start yields a fresh full window with counts from 0.
